code_rom_arbiter: RTL and testbench
===================================

Name: code_rom_arbiter

Overview:
Shares the single combinational code ROM between the instruction-fetch port (32-bit words) and a load port (32-bit word or 64-bit doubleword reads of constants in the code segment). It sits between the fetch stage/LSU and the ROM, sequences two-beat doubleword reads, and performs alignment and range checks. It also bounds fetch priority so that loads are never starved.

Parameters:
ADDR_WIDTH, 64, byte-address width of both request ports and of rom_addr_o
DATA_WIDTH, 32, ROM word width; the load response is 2*DATA_WIDTH
ROM_SIZE, 16, log2 of the ROM byte-address window; any address at or above 2**ROM_SIZE is out of range
MAX_IF_STREAK, 4, consecutive fetch grants allowed while a load is pending (1..15)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
if_req_valid_i  in  1  fetch request valid
if_req_ready_o  out  1  fetch request accepted this cycle
if_req_addr_i  in  ADDR_WIDTH  fetch byte address
if_rsp_valid_o  out  1  fetch response pulse; no backpressure
if_rsp_data_o  out  DATA_WIDTH  instruction word
if_rsp_err_o  out  1  misaligned or out-of-range fetch
ld_req_valid_i  in  1  load request valid
ld_req_ready_o  out  1  load request accepted this cycle
ld_req_addr_i  in  ADDR_WIDTH  load byte address
ld_req_dw_i  in  1  1 = 64-bit doubleword, 0 = 32-bit word (zero-extended)
ld_rsp_valid_o  out  1  load response pulse; no backpressure
ld_rsp_data_o  out  2*DATA_WIDTH  load data, little-endian {hi,lo}
ld_rsp_err_o  out  1  misaligned or out-of-range load
rom_addr_o  out  ADDR_WIDTH  address to ROM, combinational
rom_data_i  in  DATA_WIDTH  ROM read data, same cycle
rom_illegal_i  in  1  ROM unaligned flag, same cycle

Behaviour:
- Reset values: state IDLE, streak = 0, all *_rsp_valid_o/data/err = 0, readies = 0 while in reset; rom_addr_o = 0.
- States: IDLE, LD_HI.
- IDLE, grant rule:
  - Fetch wins if if_req_valid_i and (!ld_req_valid_i or streak < MAX_IF_STREAK); otherwise a valid load wins.
  - Only the winner's ready is asserted; the loser's ready is 0.
  - Accept = valid && ready. On accept, rom_addr_o = request address in the same cycle.
  - With no accept, rom_addr_o = 0.
- Streak counter:
  - +1, saturating at MAX_IF_STREAK, on each fetch accept while ld_req_valid_i = 1.
  - Cleared on load accept or whenever ld_req_valid_i = 0.
- Error check, done at accept:
  - err if addr[ADDR_WIDTH-1:ROM_SIZE] != 0, or rom_illegal_i = 1, or (dw and addr[2] != 0).
  - An error response carries data 0 and takes no second beat.
- Fetch and word load: response valid exactly 1 cycle after accept. Data is the registered rom_data_i; the word load is zero-extended to 64 bits.
- Doubleword load without error:
  - Cycle 0 (IDLE): accept; register lo = rom_data_i and addr+4; go to LD_HI.
  - Cycle 1 (LD_HI): rom_addr_o = addr+4; both readies 0; capture hi; err |= rom_illegal_i; go to IDLE.
  - Cycle 2: ld_rsp_valid_o = 1 with data {hi,lo}. Latency 2.
- Response valids are single-cycle pulses; requesters must take them. A new accept may occur in the same cycle a response is presented, giving one fetch per cycle back-to-back.
- Simultaneous requests with streak == MAX_IF_STREAK: the load is granted and the streak is cleared.
- Address wrap: ROM addresses are never wrapped; high bits produce an error instead.
- Reset asserted mid-doubleword: the in-flight load is dropped with no response, and the FSM returns to IDLE asynchronously.

Decomposition:
- Package code_rom_pkg holds:
  - arb_state_e {IDLE, LD_HI}
  - DW_ALIGN_BIT = 2
  - default width constants shared with the ROM
- No sub-module; the streak counter and FSM stay inline.

Test Plan:
- Fetch 0x0000_0010 with ROM word 0x0000_0013 -> if_rsp_valid_o 1 cycle later, data 0x00000013, err 0.
- Doubleword load at 0x0000_0100, words 0x11111111 (0x100) and 0x22222222 (0x104) -> rom_addr_o 0x100 then 0x104, ld_req_ready_o low in LD_HI, response at cycle 2 = 0x22222222_11111111.
- Fetch and load held valid every cycle, MAX_IF_STREAK = 4 -> grants IF,IF,IF,IF,LD,IF...; the load response arrives within 6 cycles.
- Load dw at 0x104 -> err 1, data 0, latency 1, no LD_HI. Fetch 0x2 -> rom_illegal_i propagates to if_rsp_err_o. Fetch 0x1_0000 (ROM_SIZE = 16) -> err 1.
- rst_ni pulsed low during LD_HI -> no ld_rsp_valid_o afterwards, state IDLE, streak 0, the next fetch is served normally.
- Back-to-back fetches 0x0, 0x4, 0x8 with no loads -> ready high every cycle, three consecutive response pulses in order.

Source files
------------

// File: rtl/code_rom_arbiter_pkg.sv
// Shared types and constants for the code ROM arbiter.
// Holds the arbiter FSM state type, the doubleword alignment bit and the
// default widths shared with the code ROM itself.
package code_rom_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LD_HI
  } arb_state_e;

  // Address bit that must be clear for a doubleword load.
  localparam int unsigned DW_ALIGN_BIT = 2;

  localparam int unsigned CODE_ROM_ADDR_WIDTH    = 64;
  localparam int unsigned CODE_ROM_DATA_WIDTH    = 32;
  localparam int unsigned CODE_ROM_SIZE          = 16;
  localparam int unsigned CODE_ROM_MAX_IF_STREAK = 4;

endpackage

// File: rtl/code_rom_arbiter_if.sv
// Bus bundle between the fetch stage / LSU, the arbiter and the code ROM.
//   fetch port : if_req_valid/ready/addr, if_rsp_valid/data/err
//   load port  : ld_req_valid/ready/addr/dw, ld_rsp_valid/data/err
//   ROM port   : rom_addr (to ROM), rom_data / rom_illegal (from ROM)
// slave  : arbiter view.
// master : requesters plus ROM view (the environment around the arbiter).
interface code_rom_arbiter_if
  import code_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CODE_ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CODE_ROM_DATA_WIDTH
) ();

  logic                    if_req_valid_i;
  logic                    if_req_ready_o;
  logic [ADDR_WIDTH-1:0]   if_req_addr_i;
  logic                    if_rsp_valid_o;
  logic [DATA_WIDTH-1:0]   if_rsp_data_o;
  logic                    if_rsp_err_o;

  logic                    ld_req_valid_i;
  logic                    ld_req_ready_o;
  logic [ADDR_WIDTH-1:0]   ld_req_addr_i;
  logic                    ld_req_dw_i;
  logic                    ld_rsp_valid_o;
  logic [2*DATA_WIDTH-1:0] ld_rsp_data_o;
  logic                    ld_rsp_err_o;

  logic [ADDR_WIDTH-1:0]   rom_addr_o;
  logic [DATA_WIDTH-1:0]   rom_data_i;
  logic                    rom_illegal_i;

  modport slave (
    input  if_req_valid_i, if_req_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    input  ld_req_valid_i, ld_req_addr_i, ld_req_dw_i,
    output ld_req_ready_o, ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_err_o,
    output rom_addr_o,
    input  rom_data_i, rom_illegal_i
  );

  modport master (
    output if_req_valid_i, if_req_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o, if_rsp_err_o,
    output ld_req_valid_i, ld_req_addr_i, ld_req_dw_i,
    input  ld_req_ready_o, ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_err_o,
    input  rom_addr_o,
    output rom_data_i, rom_illegal_i
  );

endinterface

// File: rtl/code_rom_arbiter.sv
// Arbiter sharing one combinational code ROM between instruction fetch
// (32-bit words) and a load port (32-bit word or 64-bit doubleword).
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous reset, active-low
//   bus    : code_rom_arbiter_if.slave -- fetch, load and ROM signals
// Fetch has priority, but only for MAX_IF_STREAK consecutive grants while a
// load waits. Doubleword loads take a second ROM beat in LD_HI. Responses are
// registered single-cycle pulses with no backpressure.
module code_rom_arbiter
  import code_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = CODE_ROM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = CODE_ROM_DATA_WIDTH,
  parameter int unsigned ROM_SIZE      = CODE_ROM_SIZE,
  parameter int unsigned MAX_IF_STREAK = CODE_ROM_MAX_IF_STREAK
) (
  input logic               clk_i,
  input logic               rst_ni,
  code_rom_arbiter_if.slave bus
);

  localparam logic [3:0]            MaxStreak = 4'(MAX_IF_STREAK);
  localparam logic [ADDR_WIDTH-1:0] WordBytes = ADDR_WIDTH'(DATA_WIDTH / 8);

  arb_state_e              state_q, state_d;
  logic [3:0]              streak_q, streak_d;

  logic                    if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_WIDTH-1:0]   if_rsp_data_q, if_rsp_data_d;
  logic                    if_rsp_err_q, if_rsp_err_d;

  logic                    ld_rsp_valid_q, ld_rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] ld_rsp_data_q, ld_rsp_data_d;
  logic                    ld_rsp_err_q, ld_rsp_err_d;

  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [ADDR_WIDTH-1:0]   hi_addr_q, hi_addr_d;

  logic                    fetch_win;
  logic                    if_ready, ld_ready;
  logic                    if_err, ld_err;
  logic [ADDR_WIDTH-1:0]   rom_addr;

  // Addresses are never wrapped into the ROM window; any high bit is an error.
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> ROM_SIZE) != '0;
  endfunction

  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = if_rsp_err_q;
    ld_rsp_valid_d = 1'b0;
    ld_rsp_data_d  = ld_rsp_data_q;
    ld_rsp_err_d   = ld_rsp_err_q;
    lo_d           = lo_q;
    hi_addr_d      = hi_addr_q;
    fetch_win      = 1'b0;
    if_ready       = 1'b0;
    ld_ready       = 1'b0;
    if_err         = 1'b0;
    ld_err         = 1'b0;
    rom_addr       = '0;

    unique case (state_q)
      IDLE: begin
        fetch_win = bus.if_req_valid_i &&
                    (!bus.ld_req_valid_i || (streak_q < MaxStreak));
        // Readies are forced low while reset is held.
        if_ready  = rst_ni && fetch_win;
        ld_ready  = rst_ni && !fetch_win && bus.ld_req_valid_i;

        if (if_ready) begin
          rom_addr       = bus.if_req_addr_i;
          if_err         = out_of_range(bus.if_req_addr_i) || bus.rom_illegal_i;
          if_rsp_valid_d = 1'b1;
          if_rsp_err_d   = if_err;
          if_rsp_data_d  = if_err ? '0 : bus.rom_data_i;
        end else if (ld_ready) begin
          rom_addr = bus.ld_req_addr_i;
          ld_err   = out_of_range(bus.ld_req_addr_i) || bus.rom_illegal_i ||
                     (bus.ld_req_dw_i && bus.ld_req_addr_i[DW_ALIGN_BIT]);
          if (bus.ld_req_dw_i && !ld_err) begin
            lo_d      = bus.rom_data_i;
            hi_addr_d = bus.ld_req_addr_i + WordBytes;
            state_d   = LD_HI;
          end else begin
            ld_rsp_valid_d = 1'b1;
            ld_rsp_err_d   = ld_err;
            ld_rsp_data_d  = ld_err ? '0 : {{DATA_WIDTH{1'b0}}, bus.rom_data_i};
          end
        end

        // The streak only measures fetch grants taken while a load waits.
        if (!bus.ld_req_valid_i || ld_ready) begin
          streak_d = '0;
        end else if (if_ready && (streak_q < MaxStreak)) begin
          streak_d = streak_q + 4'd1;
        end
      end

      LD_HI: begin
        rom_addr       = hi_addr_q;
        state_d        = IDLE;
        ld_rsp_valid_d = 1'b1;
        ld_rsp_err_d   = bus.rom_illegal_i;
        ld_rsp_data_d  = bus.rom_illegal_i ? '0 : {bus.rom_data_i, lo_q};
        if (!bus.ld_req_valid_i) begin
          streak_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      streak_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ld_rsp_valid_q <= 1'b0;
      ld_rsp_data_q  <= '0;
      ld_rsp_err_q   <= 1'b0;
      lo_q           <= '0;
      hi_addr_q      <= '0;
    end else begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ld_rsp_valid_q <= ld_rsp_valid_d;
      ld_rsp_data_q  <= ld_rsp_data_d;
      ld_rsp_err_q   <= ld_rsp_err_d;
      lo_q           <= lo_d;
      hi_addr_q      <= hi_addr_d;
    end
  end

  assign bus.if_req_ready_o = if_ready;
  assign bus.ld_req_ready_o = ld_ready;
  assign bus.rom_addr_o     = rom_addr;
  assign bus.if_rsp_valid_o = if_rsp_valid_q;
  assign bus.if_rsp_data_o  = if_rsp_data_q;
  assign bus.if_rsp_err_o   = if_rsp_err_q;
  assign bus.ld_rsp_valid_o = ld_rsp_valid_q;
  assign bus.ld_rsp_data_o  = ld_rsp_data_q;
  assign bus.ld_rsp_err_o   = ld_rsp_err_q;

endmodule

// File: tb/tb_code_rom_arbiter.sv
// Self-checking bench for code_rom_arbiter: directed cases followed by random
// traffic, checked against a reference model with a response scoreboard.
module tb_code_rom_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam logic [63:0] RomLimit  = 64'h1 << 16;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  logic clk;
  logic rst_n;

  code_rom_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  code_rom_arbiter #(
    .ADDR_WIDTH   (64),
    .DATA_WIDTH   (32),
    .ROM_SIZE     (16),
    .MAX_IF_STREAK(MaxStreak)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Behavioural ROM: a few fixed words, a hash everywhere else.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    case (a)
      64'h10:  return 32'h0000_0013;
      64'h100: return 32'h1111_1111;
      64'h104: return 32'h2222_2222;
      default: return (a[31:0] * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus.rom_data_i    = rom_word(bus.rom_addr_o);
  assign bus.rom_illegal_i = (bus.rom_addr_o[1:0] != 2'b00);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks;
  int   passes;
  exp_t if_q[$];
  exp_t ld_q[$];

  // Reference model state.
  bit          busy;
  logic [63:0] hi_addr_m;
  int unsigned wait_cnt;
  bit          if_acc;
  bit          ld_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic void model(input logic [63:0] a, input logic dw,
                                output logic err, output logic [63:0] d);
    err = (a >= RomLimit) || (a[1:0] != 2'b00) || (dw && a[2]);
    if (err) d = '0;
    else if (dw) d = {rom_word(a + 64'd4), rom_word(a)};
    else d = {32'h0, rom_word(a)};
  endfunction

  // Called at the falling edge: checks grants and ROM address, records accepts.
  task automatic evaluate();
    logic        exp_if, exp_ld, err, busy_next;
    logic [63:0] exp_rom, d;
    if_acc = 0;
    ld_acc = 0;
    if (!rst_n) begin
      check("rst_if_ready", bus.if_req_ready_o, 0);
      check("rst_ld_ready", bus.ld_req_ready_o, 0);
      check("rst_rom_addr", bus.rom_addr_o, 0);
      check("rst_if_rsp", {bus.if_rsp_valid_o, bus.if_rsp_err_o, bus.if_rsp_data_o}, 0);
      check("rst_ld_rsp", {bus.ld_rsp_valid_o, bus.ld_rsp_err_o}, 0);
      check("rst_ld_data", bus.ld_rsp_data_o, 0);
      return;
    end
    if (busy) begin
      exp_if  = 0;
      exp_ld  = 0;
      exp_rom = hi_addr_m;
    end else begin
      exp_if  = bus.if_req_valid_i && (!bus.ld_req_valid_i || wait_cnt < MaxStreak);
      exp_ld  = !exp_if && bus.ld_req_valid_i;
      exp_rom = exp_if ? bus.if_req_addr_i : (exp_ld ? bus.ld_req_addr_i : 64'h0);
    end
    check("if_ready", bus.if_req_ready_o, exp_if);
    check("ld_ready", bus.ld_req_ready_o, exp_ld);
    check("rom_addr", bus.rom_addr_o, exp_rom);
    busy_next = 0;
    if (exp_if) begin
      model(bus.if_req_addr_i, 1'b0, err, d);
      if_q.push_back('{data: d, err: err, due: cyc + 1});
      if_acc = 1;
    end
    if (exp_ld) begin
      model(bus.ld_req_addr_i, bus.ld_req_dw_i, err, d);
      if (bus.ld_req_dw_i && !err) begin
        busy_next = 1;
        hi_addr_m = bus.ld_req_addr_i + 64'd4;
        ld_q.push_back('{data: d, err: err, due: cyc + 2});
      end else begin
        ld_q.push_back('{data: d, err: err, due: cyc + 1});
      end
      ld_acc = 1;
    end
    // Fetch grants counted since the current load started waiting.
    if (!bus.ld_req_valid_i || exp_ld) wait_cnt = 0;
    else if (exp_if && wait_cnt < MaxStreak) wait_cnt++;
    busy = busy_next;
  endtask

  task automatic step();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int max_cycles);
    int n = 0;
    while ((bus.if_req_valid_i || bus.ld_req_valid_i) && n < max_cycles) begin
      step();
      n++;
      if (if_acc) bus.if_req_valid_i = 1'b0;
      if (ld_acc) bus.ld_req_valid_i = 1'b0;
    end
    check("req_accept_timeout", {bus.if_req_valid_i, bus.ld_req_valid_i}, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    a = 64'($urandom_range(0, 32'hFFFF)) & ~64'h7;
    case (r)
      0: a = a | 64'($urandom_range(1, 3));
      1: a = a | (64'h1 << $urandom_range(16, 63));
      2: a = a | 64'h4;
      3: a = 64'hFFF8;
      default: ;
    endcase
    return a;
  endfunction

  // Scoreboard monitor: pops an expectation whenever a response pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.if_rsp_valid_o) begin
        if (if_q.size() == 0) begin
          check("if_unexpected_rsp", 1, 0);
        end else begin
          e = if_q.pop_front();
          check("if_data", {32'h0, bus.if_rsp_data_o}, e.data);
          check("if_err", bus.if_rsp_err_o, e.err);
          check("if_latency", cyc, e.due);
        end
      end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
        check("if_missing_rsp", 0, 1);
        void'(if_q.pop_front());
      end
      if (bus.ld_rsp_valid_o) begin
        if (ld_q.size() == 0) begin
          check("ld_unexpected_rsp", 1, 0);
        end else begin
          e = ld_q.pop_front();
          check("ld_data", bus.ld_rsp_data_o, e.data);
          check("ld_err", bus.ld_rsp_err_o, e.err);
          check("ld_latency", cyc, e.due);
        end
      end else if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
        check("ld_missing_rsp", 0, 1);
        void'(ld_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ld_wait;
    cyc      = 0;
    checks   = 0;
    passes   = 0;
    busy     = 0;
    wait_cnt = 0;
    rst_n    = 1'b0;
    // A fetch held during reset must not be granted until reset lifts.
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h10;
    bus.ld_req_valid_i = 1'b0;
    bus.ld_req_addr_i  = '0;
    bus.ld_req_dw_i    = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Fetch 0x10 -> 0x13.
    run_until_done(4);
    idle(2);

    // Doubleword at 0x100 -> 0x22222222_11111111 at latency 2.
    bus.ld_req_valid_i = 1'b1;
    bus.ld_req_addr_i  = 64'h100;
    bus.ld_req_dw_i    = 1'b1;
    run_until_done(4);
    idle(3);

    // Both held valid: four fetches, then the load.
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h20;
    bus.ld_req_valid_i = 1'b1;
    bus.ld_req_addr_i  = 64'h200;
    bus.ld_req_dw_i    = 1'b0;
    ld_wait = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_acc) bus.if_req_addr_i = bus.if_req_addr_i + 64'd4;
      if (ld_acc) begin
        ld_wait = i + 1;
        bus.ld_req_valid_i = 1'b0;
      end
    end
    bus.if_req_valid_i = 1'b0;
    check("ld_wait_cycles", 64'(ld_wait), 64'd5);
    idle(2);

    // Error cases.
    bus.ld_req_valid_i = 1'b1;
    bus.ld_req_addr_i  = 64'h104;
    bus.ld_req_dw_i    = 1'b1;
    run_until_done(4);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h2;
    run_until_done(4);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h1_0000;
    run_until_done(4);
    idle(2);

    // Reset while the second beat of a doubleword is in flight.
    bus.ld_req_valid_i = 1'b1;
    bus.ld_req_addr_i  = 64'h100;
    bus.ld_req_dw_i    = 1'b1;
    step();
    check("rst_dw_accept", ld_acc, 1);
    bus.ld_req_valid_i = 1'b0;
    #2;
    rst_n    = 1'b0;
    busy     = 0;
    wait_cnt = 0;
    ld_q.delete();
    if_q.delete();
    step();
    rst_n = 1'b1;
    idle(3);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h30;
    run_until_done(4);
    idle(2);

    // Back-to-back fetches.
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 64'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_accept", if_acc, 1);
      bus.if_req_addr_i = bus.if_req_addr_i + 64'd4;
    end
    bus.if_req_valid_i = 1'b0;
    idle(2);

    // Random traffic; requests are held until accepted.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!bus.if_req_valid_i || if_acc) begin
        bus.if_req_valid_i = ($urandom_range(0, 99) < 60);
        bus.if_req_addr_i  = rand_addr();
      end
      if (!bus.ld_req_valid_i || ld_acc) begin
        bus.ld_req_valid_i = ($urandom_range(0, 99) < 40);
        bus.ld_req_addr_i  = rand_addr();
        bus.ld_req_dw_i    = 1'($urandom_range(0, 1));
      end
    end
    bus.if_req_valid_i = 1'b0;
    bus.ld_req_valid_i = 1'b0;
    idle(4);
    check("if_q_drained", 64'(if_q.size()), 0);
    check("ld_q_drained", 64'(ld_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
